// File: rtl/switch_input_conditioner_pkg.sv
// Shared types and constants for the switch input conditioner.
// Also holds the priority-encode helper used for the selection outputs.
package sw_pkg;

   localparam int CLK_HZ        = 100000000;
   localparam int DEBOUNCE_10MS = 1000000;

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } sw_state_e;

   // Index of the highest set bit; 0 when nothing is set.
   function automatic logic [2:0] sel_encode(input logic [7:0] v);
      logic [2:0] code;
      code = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) code = 3'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/switch_input_conditioner_if.sv
// Switch bus between the board pins/consumer logic and the conditioner.
// The master side drives raw pins; the slave side (conditioner) drives clean outputs.
interface switch_input_conditioner_if #(
   parameter int NUM_SW = 4
);
   logic [NUM_SW-1:0] SW_N;
   logic [NUM_SW-1:0] SW_STATE;
   logic [NUM_SW-1:0] SW_PRESS;
   logic [NUM_SW-1:0] SW_RELEASE;
   logic [2:0]        SEL_CODE;
   logic              SEL_VALID;
   logic              SEL_CHANGE;

   modport master (
      output SW_N,
      input  SW_STATE, SW_PRESS, SW_RELEASE, SEL_CODE, SEL_VALID, SEL_CHANGE
   );

   modport slave (
      input  SW_N,
      output SW_STATE, SW_PRESS, SW_RELEASE, SEL_CODE, SEL_VALID, SEL_CHANGE
   );
endinterface

// File: rtl/switch_input_conditioner_debounce.sv
// One switch bit: 2-flop synchroniser, debounce FSM, press/release pulses.
// Auto-repeat of the press pulse while held is built only with SW_AUTOREPEAT_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  RELEASED | accepted level is released; counting press run
//  PRESSED  | accepted level is pressed; counting release run
module switch_debounce_cell
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic pin_n,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("switch_debounce_cell: cycle parameters must be >= 1");
   end

   logic      sync1, sync2, raw_p;
   sw_state_e st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic      press_nxt, rel_nxt, rpt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= pin_n;
         sync2 <= sync1;
      end
   end

   assign raw_p = ~sync2;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st    <= RELEASED;
         cnt   <= '0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         st    <= st_nxt;
         cnt   <= cnt_nxt;
         press <= press_nxt | rpt;
         rel   <= rel_nxt;
      end
   end

   // The counter only advances while the input disagrees with the state,
   // so it can never pass CNT_LAST.
   always_comb begin
      st_nxt    = st;
      cnt_nxt   = '0;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      case (st)
         RELEASED: begin
            if (raw_p) begin
               if (cnt == CNT_LAST) begin
                  st_nxt    = PRESSED;
                  press_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         PRESSED: begin
            if (!raw_p) begin
               if (cnt == CNT_LAST) begin
                  st_nxt  = RELEASED;
                  rel_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: st_nxt = RELEASED;
      endcase
   end

   assign level = (st == PRESSED);

`ifdef SW_AUTOREPEAT_EN
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);

   logic [HW-1:0] hold_cnt, hold_nxt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) hold_cnt <= '0;
      else        hold_cnt <= hold_nxt;
   end

   // Down-counter: loaded with the hold time on press, then with the repeat period.
   always_comb begin
      hold_nxt = '0;
      rpt      = 1'b0;
      if (st == RELEASED && st_nxt == PRESSED) begin
         hold_nxt = HW'(HOLD_CYCLES - 1);
      end else if (st == PRESSED && st_nxt == PRESSED) begin
         if (hold_cnt == '0) begin
            rpt      = 1'b1;
            hold_nxt = HW'(REPEAT_CYCLES - 1);
         end else begin
            hold_nxt = hold_cnt - 1'b1;
         end
      end
   end
`else
   assign rpt = 1'b0;
`endif

endmodule

// File: rtl/switch_input_conditioner.sv
// Top: NUM_SW debounce cells plus a registered highest-index priority encoder.
// Optional press auto-repeat is enabled with the SW_AUTOREPEAT_EN macro.
module switch_input_conditioner
   import sw_pkg::*;
#(
   parameter int NUM_SW          = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic CLK,
   input  logic RST_N,
   switch_input_conditioner_if.slave sw_bus
);

   logic [NUM_SW-1:0] state;
   logic [2:0]        code_q, code_nxt;
   logic              valid_q, valid_nxt, change_q;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
      switch_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_cell (
         .CLK   (CLK),
         .RST_N (RST_N),
         .pin_n (sw_bus.SW_N[i]),
         .level (state[i]),
         .press (sw_bus.SW_PRESS[i]),
         .rel   (sw_bus.SW_RELEASE[i])
      );
   end

   assign code_nxt  = sel_encode(8'(state));
   assign valid_nxt = |state;

   // Change is judged on the full {valid, code} pair, so a lower switch
   // toggling under a held higher one is invisible here.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         code_q   <= '0;
         valid_q  <= 1'b0;
         change_q <= 1'b0;
      end else begin
         code_q   <= code_nxt;
         valid_q  <= valid_nxt;
         change_q <= {valid_nxt, code_nxt} != {valid_q, code_q};
      end
   end

   assign sw_bus.SW_STATE   = state;
   assign sw_bus.SEL_CODE   = code_q;
   assign sw_bus.SEL_VALID  = valid_q;
   assign sw_bus.SEL_CHANGE = change_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Scoreboard bench: a history-window reference model pushes expected outputs
// every cycle; a negedge monitor pops and compares against the DUT.
module tb_switch_input_conditioner;

   localparam int N = 4;
   localparam int D = 8;
   localparam int H = 40;
   localparam int R = 16;

   typedef struct packed {
      logic [N-1:0] st;
      logic [N-1:0] pr;
      logic [N-1:0] rl;
      logic [2:0]   code;
      logic         valid;
      logic         chg;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] sw_drv;

   always #5 clk = ~clk;

   switch_input_conditioner_if #(.NUM_SW(N)) bus ();
   assign bus.SW_N = sw_drv;

   switch_input_conditioner #(
      .NUM_SW          (N),
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .REPEAT_CYCLES   (R)
   ) dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .sw_bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int obs_press [N];

   exp_t         sb [$];
   logic [N-1:0] hist [$];
   logic [N-1:0] m_st;
   logic [2:0]   m_code;
   logic         m_valid;
   int           m_age [N];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back('0);
      m_st    = '0;
      m_code  = '0;
      m_valid = 1'b0;
      for (int b = 0; b < N; b++) m_age[b] = 0;
   endtask

   // Reference: a bit flips when the D samples seen through the 2-cycle
   // synchroniser delay all disagree with its current accepted level.
   always @(posedge clk) begin
      exp_t         e;
      logic [N-1:0] prev;
      logic         opp;
      int           t, idx;
      logic [2:0]   c_new;
      logic         v_new;
      e = '0;
      if (!rst_n) begin
         model_clear();
      end else begin
         hist.push_front(~sw_drv);
         void'(hist.pop_back());
         prev = m_st;
         for (int b = 0; b < N; b++) begin
            opp = 1'b1;
            for (int k = 2; k <= D + 1; k++)
               if (hist[k][b] == prev[b]) opp = 1'b0;
            if (opp) begin
               m_st[b] = ~prev[b];
               if (m_st[b]) begin
                  e.pr[b]  = 1'b1;
                  m_age[b] = 0;
               end else begin
                  e.rl[b] = 1'b1;
               end
            end else if (prev[b]) begin
               m_age[b]++;
`ifdef SW_AUTOREPEAT_EN
               if (m_age[b] == H || (m_age[b] > H && (m_age[b] - H) % R == 0))
                  e.pr[b] = 1'b1;
`endif
            end
         end
         t   = int'(prev);
         idx = 0;
         while (t > 1) begin
            t = t / 2;
            idx++;
         end
         c_new   = 3'(idx);
         v_new   = (prev != 0);
         e.chg   = ({v_new, c_new} != {m_valid, m_code});
         m_valid = v_new;
         m_code  = c_new;
         e.st    = m_st;
         e.code  = m_code;
         e.valid = m_valid;
      end
      sb.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL sb_empty at %0t: got no expected entry, required one", $time);
      end else begin
         e = sb.pop_front();
         if (!rst_n) e = '0;
         chk("sw_state",   int'(bus.SW_STATE),   int'(e.st));
         chk("sw_press",   int'(bus.SW_PRESS),   int'(e.pr));
         chk("sw_release", int'(bus.SW_RELEASE), int'(e.rl));
         chk("sel_code",   int'(bus.SEL_CODE),   int'(e.code));
         chk("sel_valid",  int'(bus.SEL_VALID),  int'(e.valid));
         chk("sel_change", int'(bus.SEL_CHANGE), int'(e.chg));
      end
      for (int b = 0; b < N; b++) obs_press[b] += int'(bus.SW_PRESS[b]);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int run [N];
      for (int b = 0; b < N; b++) obs_press[b] = 0;
      rst_n  = 1'b0;
      sw_drv = '1;
      step(3);
      rst_n = 1'b1;
      step(20);

      obs_press[1] = 0;
      sw_drv[1] = 1'b0;
      step(20);
      chk("sw1_single_press", obs_press[1], 1);

      sw_drv[0] = 1'b0; step(5);
      sw_drv[0] = 1'b1; step(12);
      sw_drv[0] = 1'b0; step(5);
      sw_drv[0] = 1'b1; step(1);
      sw_drv[0] = 1'b0; step(5);
      sw_drv[0] = 1'b1; step(12);

      sw_drv[3] = 1'b0; step(15);
      sw_drv[1] = 1'b1; step(15);
      sw_drv[3] = 1'b1; step(15);

      sw_drv[2] = 1'b0; step(7);
      rst_n = 1'b0; step(3);
      rst_n = 1'b1; step(15);
      sw_drv[2] = 1'b1; step(15);

      obs_press[0] = 0;
      sw_drv[0] = 1'b0; step(100);
      sw_drv[0] = 1'b1; step(15);
`ifdef SW_AUTOREPEAT_EN
      chk("sw0_repeat_count", obs_press[0], 5);
`else
      chk("sw0_repeat_count", obs_press[0], 1);
`endif

      for (int b = 0; b < N; b++) run[b] = $urandom_range(1, 14);
      for (int c = 0; c < 700; c++) begin
         for (int b = 0; b < N; b++) begin
            if (run[b] == 0) begin
               sw_drv[b] = ~sw_drv[b];
               run[b]    = $urandom_range(1, 14);
            end else begin
               run[b]--;
            end
         end
         if (c == 350) rst_n = 1'b0;
         if (c == 353) rst_n = 1'b1;
         step(1);
      end

      sw_drv = '1;
      step(25);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
